// File: rtl/writeback_arbiter.sv
// Register file write-port arbiter: merges execute (A) and buffered load/multicycle (B) results.
// Optional WRITEBACK_BYPASS_EN lets an accepted B result skip an empty FIFO when A is idle.
module writeback_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        aValid,
  input  logic [4:0]  aRdAddress,
  input  logic [31:0] aData,
  output logic        aStall,
  input  logic        bValid,
  output logic        bReady,
  input  logic [4:0]  bRdAddress,
  input  logic [31:0] bData,
  input  logic [4:0]  checkAddress1,
  input  logic [4:0]  checkAddress2,
  output logic        hazard1,
  output logic        hazard2,
  output logic [31:0] rd,
  output logic [4:0]  rdAddress,
  output logic        writeEnable
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   count;
  logic [SW-1:0]   starve_count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            a_win;
  logic            bypass;
  logic            sel_load;
  entry_t          sel;
  entry_t          head;
  logic [AW-1:0]   offset;
  logic            hit1;
  logic            hit2;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign bReady = !full && !reset;
  assign aStall = (starve_count == SW'(STARVE_LIMIT)) && !empty;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
    pop      = 1'b0;
    a_win    = 1'b0;
    bypass   = 1'b0;
    sel_load = 1'b0;
    sel      = '0;
    if (aStall) begin
      pop      = 1'b1;
      sel_load = 1'b1;
      sel      = head;
    end else if (aValid) begin
      a_win    = 1'b1;
      sel_load = 1'b1;
      sel      = '{addr: aRdAddress, data: aData};
    end else if (!empty) begin
      pop      = 1'b1;
      sel_load = 1'b1;
      sel      = head;
    end
`ifdef WRITEBACK_BYPASS_EN
    else if (bValid && bReady) begin
      bypass   = 1'b1;
      sel_load = 1'b1;
      sel      = '{addr: bRdAddress, data: bData};
    end
`else
`endif
  end

  // bReady already excludes a full FIFO, so a pop in the same cycle never opens room for a push.
  assign push = bValid && bReady && !bypass;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      starve_count <= '0;
      writeEnable  <= 1'b0;
      rdAddress    <= '0;
      rd           <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      if (pop || empty) begin
        starve_count <= '0;
      end else if (a_win && (starve_count != SW'(STARVE_LIMIT))) begin
        starve_count <= starve_count + SW'(1);
      end

      if (sel_load) begin
        writeEnable <= (sel.addr != 5'd0);
        rdAddress   <= sel.addr;
        rd          <= sel.data;
      end else begin
        writeEnable <= 1'b0;
      end
    end
  end

  // NOTE: the storage array is not reset; slot validity comes solely from the pointers.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{addr: bRdAddress, data: bData};
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    hit1   = 1'b0;
    hit2   = 1'b0;
    offset = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      offset = AW'(i) - rd_ptr[AW-1:0];
      if ({1'b0, offset} < count) begin
        if (mem[i].addr == checkAddress1) hit1 = 1'b1;
        if (mem[i].addr == checkAddress2) hit2 = 1'b1;
      end
    end
  end

  assign hazard1 = (checkAddress1 != 5'd0) &&
                   (hit1 || (writeEnable && (rdAddress == checkAddress1)));
  assign hazard2 = (checkAddress2 != 5'd0) &&
                   (hit2 || (writeEnable && (rdAddress == checkAddress2)));

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef WRITEBACK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        aValid = 1'b0;
  logic [4:0]  aRdAddress = '0;
  logic [31:0] aData = '0;
  logic        aStall;
  logic        bValid = 1'b0;
  logic        bReady;
  logic [4:0]  bRdAddress = '0;
  logic [31:0] bData = '0;
  logic [4:0]  checkAddress1 = '0;
  logic [4:0]  checkAddress2 = '0;
  logic        hazard1;
  logic        hazard2;
  logic [31:0] rd;
  logic [4:0]  rdAddress;
  logic        writeEnable;

  always #5 clock = ~clock;

  writeback_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .aValid(aValid), .aRdAddress(aRdAddress), .aData(aData), .aStall(aStall),
    .bValid(bValid), .bReady(bReady), .bRdAddress(bRdAddress), .bData(bData),
    .checkAddress1(checkAddress1), .checkAddress2(checkAddress2),
    .hazard1(hazard1), .hazard2(hazard2),
    .rd(rd), .rdAddress(rdAddress), .writeEnable(writeEnable)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        fifo_q[$];
  int          starve;
  logic        m_we;
  logic [4:0]  m_ra;
  logic [31:0] m_rd;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          accepted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_hazard(input logic [4:0] c);
    if (c == 5'd0) return 1'b0;
    foreach (fifo_q[i]) if (fifo_q[i].addr == c) return 1'b1;
    return m_we && (m_ra == c);
  endfunction

  function automatic void model_clear();
    fifo_q.delete();
    starve = 0;
    m_we   = 1'b0;
    m_ra   = '0;
    m_rd   = '0;
  endfunction

  // One clock: check combinational outputs before the edge, advance model, check registers after.
  task automatic step();
    bit   m_bready, m_astall, take, was_empty, load, popped, awin, byp;
    ent_t nb, out;
    #1;
    m_bready = !reset && (fifo_q.size() < DEPTH);
    m_astall = (starve == LIMIT) && (fifo_q.size() != 0);
    check("bReady", bReady, m_bready);
    check("aStall", aStall, m_astall);
    check("hazard1", hazard1, m_hazard(checkAddress1));
    check("hazard2", hazard2, m_hazard(checkAddress2));
    take      = bValid && m_bready;
    accepted  = take;
    nb        = {bRdAddress, bData};
    was_empty = (fifo_q.size() == 0);
    load = 0; popped = 0; awin = 0; byp = 0; out = '0;
    if (m_astall) begin
      out = fifo_q[0]; load = 1; popped = 1;
    end else if (aValid) begin
      out = {aRdAddress, aData}; load = 1; awin = 1;
    end else if (!was_empty) begin
      out = fifo_q[0]; load = 1; popped = 1;
    end else if (BYPASS && take) begin
      out = nb; load = 1; byp = 1;
    end
    @(posedge clock);
    if (reset) begin
      model_clear();
    end else begin
      if (popped) void'(fifo_q.pop_front());
      if (take && !byp) fifo_q.push_back(nb);
      if (popped || was_empty) starve = 0;
      else if (awin && starve < LIMIT) starve++;
      if (load) begin
        m_we = (out.addr != 5'd0);
        m_ra = out.addr;
        m_rd = out.data;
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
    check("writeEnable", writeEnable, m_we);
    check("rdAddress", rdAddress, m_ra);
    check("rd", rd, m_rd);
  endtask

  task automatic idle();
    aValid = 1'b0;
    bValid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int wins;
  int k;

  initial begin
    // Bring-up: registers are unknown until the first reset edge.
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    model_clear();

    // Reset state
    step();
    check("reset_bready_low", bReady, 1'b0);
    check("reset_we", writeEnable, 1'b0);
    check("reset_rdaddr", rdAddress, 5'd0);
    check("reset_rd", rd, 32'd0);
    reset = 1'b0;
    #1;
    check("bready_after_reset", bReady, 1'b1);

    // A writes x5
    aValid = 1'b1; aRdAddress = 5'd5; aData = 32'h12345678; checkAddress1 = 5'd5;
    step();
    aValid = 1'b0;
    check("a_x5_we", writeEnable, 1'b1);
    check("a_x5_addr", rdAddress, 5'd5);
    check("a_x5_data", rd, 32'h12345678);
    check("a_x5_hazard1", hazard1, 1'b1);

    // A writes x0: discarded
    aValid = 1'b1; aRdAddress = 5'd0; aData = 32'hDEADBEEF; checkAddress1 = 5'd0;
    step();
    aValid = 1'b0;
    check("a_x0_we", writeEnable, 1'b0);
    check("a_x0_hazard1", hazard1, 1'b0);

    // B burst with A idle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bValid = 1'b1; bRdAddress = 5'(7 + i); bData = 32'(32'hA + i);
      step();
    end
    idle();
    repeat (6) step();

    // B offers with A busy: FIFO fills, fifth offer waits for a pop
    do_reset();
    aValid = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 5; cyc++) begin
      aRdAddress = 5'(1 + cyc % 4); aData = $urandom;
      bValid = 1'b1; bRdAddress = 5'(11 + k); bData = 32'(32'hB0 + k);
      step();
      if (accepted) begin
        k++;
        if (k == 4) check("full_bready", bReady, 1'b0);
      end
    end
    check("fifth_accepted", k, 5);
    idle();
    repeat (8) step();

    // Starvation limiter
    do_reset();
    aValid = 1'b1; aRdAddress = 5'd1; aData = 32'h1111;
    bValid = 1'b1; bRdAddress = 5'd7; bData = 32'hA;
    step();
    bValid = 1'b0;
    wins = 0;
    while (!aStall && wins < 20) begin
      aData = 32'(32'h2000 + wins);
      step();
      wins++;
    end
    check("starve_wins", wins, LIMIT);
    aRdAddress = 5'd2; aData = 32'h3333;
    step();
    check("starve_pop_addr", rdAddress, 5'd7);
    check("starve_pop_data", rd, 32'hA);
    check("starve_astall_fall", aStall, 1'b0);
    step();
    check("a_resumes", rdAddress, 5'd2);
    idle();
    step();

    // B latency on an idle arbiter
    do_reset();
    checkAddress2 = 5'd3;
    bValid = 1'b1; bRdAddress = 5'd3; bData = 32'h55;
    step();
    bValid = 1'b0;
    if (!BYPASS) begin
      check("b_lat_not_yet", writeEnable, 1'b0);
      check("b_lat_hazard_fifo", hazard2, 1'b1);
      step();
    end
    check("b_lat_we", writeEnable, 1'b1);
    check("b_lat_addr", rdAddress, 5'd3);
    check("b_lat_data", rd, 32'h55);
    check("b_lat_hazard_out", hazard2, 1'b1);
    step();
    check("b_retired_hazard", hazard2, 1'b0);

    // Reset mid-operation
    do_reset();
    aValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      aRdAddress = 5'd20; aData = 32'(32'hC0 + i);
      bValid = 1'b1; bRdAddress = 5'(21 + i); bData = 32'(32'hD0 + i);
      step();
    end
    check("pre_reset_we", writeEnable, 1'b1);
    idle();
    checkAddress1 = 5'd21; checkAddress2 = 5'd20;
    reset = 1'b1;
    step();
    check("midreset_we", writeEnable, 1'b0);
    check("midreset_h1", hazard1, 1'b0);
    check("midreset_h2", hazard2, 1'b0);
    reset = 1'b0;
    repeat (5) step();
    check("post_reset_bready", bReady, 1'b1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 199) == 0);
      aValid        = ($urandom_range(0, 99) < 45);
      aRdAddress    = 5'($urandom_range(0, 15));
      aData         = $urandom;
      bValid        = ($urandom_range(0, 99) < 55);
      bRdAddress    = 5'($urandom_range(0, 15));
      bData         = $urandom;
      checkAddress1 = 5'($urandom_range(0, 15));
      checkAddress2 = 5'($urandom_range(0, 15));
      step();
    end
    reset = 1'b0;
    idle();
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
